// File: rtl/pdm_fade_ramp.sv
// pdm_fade_ramp: brightness fade generator for the nixie pdm dimming stage.
// Ramps level_out toward a written target by step_reg every period_reg clocks,
// strobing level_write whenever level_out takes a new value.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   target_in       new fade target, latched on target_write
//   step_in         level increment per ramp tick, latched on cfg_write
//   period_in       clocks per ramp tick, latched on cfg_write (0 acts as 1)
//   level_out       current level, to pdm PWM_in
//   level_write     one-cycle strobe when level_out changes, to pdm pwm_write
//   busy            high while the ramp FSM is not IDLE
//   done            one-cycle pulse when level_out reaches the target
module pdm_fade_ramp #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      target_in,
  input  logic                  target_write,
  input  logic [7:0]            step_in,
  input  logic [PRESCALE_W-1:0] period_in,
  input  logic                  cfg_write,
  output logic [WIDTH-1:0]      level_out,
  output logic                  level_write,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned STEP_W = 8;
  localparam int unsigned EXT_W  = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      target_q;
  logic [STEP_W-1:0]     step_q;
  logic [PRESCALE_W-1:0] period_q;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      level_d;
  logic                  write_d;
  logic                  done_d;
  logic                  busy_d;

  logic [PRESCALE_W-1:0] period_eff;
  logic [WIDTH-1:0]      tgt_eff;
  logic                  tick;
  logic [EXT_W-1:0]      up_sum;
  logic [EXT_W-1:0]      down_floor;

  // Next-state, prescaler and level update.
  always_comb begin
    state_d    = IDLE;
    cnt_d      = cnt_q;
    level_d    = level_out;
    write_d    = 1'b0;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    period_eff = (period_q == '0) ? PRESCALE_W'(1) : period_q;
    // A retarget in the same cycle as a tick steers that tick toward the new target.
    tgt_eff    = target_write ? target_in : target_q;
    // ">=" so a shortened period mid-count ticks on the next cycle.
    tick       = (state_q != IDLE) && (cnt_q >= period_eff - PRESCALE_W'(1));
    up_sum     = EXT_W'(level_out) + EXT_W'(step_q);
    down_floor = EXT_W'(tgt_eff) + EXT_W'(step_q);

    // Direction is re-derived every cycle from the latched target.
    if (target_q > level_out)      state_d = UP;
    else if (target_q < level_out) state_d = DOWN;
    else                           state_d = IDLE;
    busy_d = (state_d != IDLE);

    // Prescaler idles at zero, so a ramp started from IDLE begins a full period.
    if (state_q == IDLE)  cnt_d = '0;
    else if (tick)        cnt_d = '0;
    else                  cnt_d = cnt_q + PRESCALE_W'(1);

    if (tick && (tgt_eff != level_out)) begin
      write_d = 1'b1;
      if (tgt_eff > level_out) begin
        if ((step_q == '0) || (up_sum >= EXT_W'(tgt_eff))) level_d = tgt_eff;
        else                                               level_d = up_sum[WIDTH-1:0];
      end else begin
        if ((step_q == '0) || (EXT_W'(level_out) <= down_floor)) level_d = tgt_eff;
        else                                                     level_d = level_out - WIDTH'(step_q);
      end
      done_d = (level_d == tgt_eff);
    end

    if (target_write && (target_in == level_out)) done_d = 1'b1;
  end

  // State, configuration and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= '0;
      step_q      <= STEP_W'(1);
      period_q    <= PRESCALE_W'(1);
      cnt_q       <= '0;
      level_out   <= '0;
      level_write <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_out   <= level_d;
      level_write <= write_d;
      busy        <= busy_d;
      done        <= done_d;
      if (target_write) target_q <= target_in;
      if (cfg_write) begin
        step_q   <= step_in;
        period_q <= period_in;
      end
    end
  end

endmodule

// File: tb/tb_pdm_fade_ramp.sv
// tb_pdm_fade_ramp: directed and randomized checks of pdm_fade_ramp against an
// arithmetic model of the expected level sequence and strobe timing.
module tb_pdm_fade_ramp;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned PW    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] target_in;
  logic             target_write;
  logic [7:0]       step_in;
  logic [PW-1:0]    period_in;
  logic             cfg_write;
  logic [WIDTH-1:0] level_out;
  logic             level_write;
  logic             busy;
  logic             done;

  pdm_fade_ramp #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .target_in    (target_in),
    .target_write (target_write),
    .step_in      (step_in),
    .period_in    (period_in),
    .cfg_write    (cfg_write),
    .level_out    (level_out),
    .level_write  (level_write),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  int sk[$];     // cycle index of each observed strobe
  int sl[$];     // level shown with each strobe
  int dk[$];     // cycle index of each done pulse
  int bh[$];     // busy per watched cycle
  int exp_l[$];  // model level sequence

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected level after each tick, from the clamp rules alone.
  task automatic build(input int from, input int to, input int stp);
    int lvl;
    exp_l.delete();
    lvl = from;
    while (lvl != to) begin
      if (stp == 0)      lvl = to;
      else if (to > lvl) lvl = (lvl + stp > to) ? to : lvl + stp;
      else               lvl = (lvl - stp < to) ? to : lvl - stp;
      exp_l.push_back(lvl);
    end
  endtask

  // Called just after a negedge; the write lands on the next posedge.
  task automatic drive(input int tgt, input bit do_tgt, input int stp, input int per, input bit do_cfg);
    target_in    = WIDTH'(tgt);
    target_write = do_tgt;
    step_in      = 8'(stp);
    period_in    = PW'(per);
    cfg_write    = do_cfg;
    @(posedge clk);
    #1;
    target_write = 1'b0;
    cfg_write    = 1'b0;
  endtask

  // Sample k=0 is the negedge right after the write edge.
  task automatic watch(input int n);
    sk.delete(); sl.delete(); dk.delete(); bh.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (level_write) begin
        sk.push_back(k);
        sl.push_back(int'(level_out));
      end
      if (done) dk.push_back(k);
      bh.push_back(int'(busy));
    end
  endtask

  task automatic verify(input string tag, input int to, input int per, input int first_k);
    int pe;
    int n;
    int last_k;
    pe = (per == 0) ? 1 : per;
    n  = exp_l.size();
    check({tag, ":strobes"}, sk.size(), n);
    for (int i = 0; i < n && i < sk.size(); i++) begin
      check($sformatf("%s:level[%0d]", tag, i), sl[i], exp_l[i]);
      check($sformatf("%s:cycle[%0d]", tag, i), sk[i], first_k + pe * i);
    end
    check({tag, ":dones"}, dk.size(), 1);
    if (n == 0) begin
      if (dk.size() > 0) check({tag, ":done_cycle"}, dk[0], 0);
      check({tag, ":busy_idle"}, bh[1], 0);
    end else begin
      last_k = first_k + pe * (n - 1);
      if (dk.size() > 0) check({tag, ":done_cycle"}, dk[0], last_k);
      check({tag, ":busy_last"}, bh[last_k], 1);
      check({tag, ":busy_fall"}, bh[last_k + 1], 0);
    end
    check({tag, ":final"}, int'(level_out), to);
  endtask

  task automatic ramp(input string tag, input int to, input int stp, input int per, input bit same);
    int pe;
    int n;
    pe = (per == 0) ? 1 : per;
    build(cur, to, stp);
    n = exp_l.size();
    if (same) begin
      drive(to, 1'b1, stp, per, 1'b1);
    end else begin
      drive(0, 1'b0, stp, per, 1'b1);
      drive(to, 1'b1, 0, 0, 1'b0);
    end
    watch((n == 0) ? 4 : 1 + pe * n + 3);
    verify(tag, to, per, 1 + pe);
    cur = to;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int found;
    int tgt;
    int stp;
    int per;
    int busy_cnt;

    rst = 1'b1; target_in = '0; target_write = 1'b0;
    step_in = '0; period_in = '0; cfg_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:level", int'(level_out), 0);
    check("reset:write", int'(level_write), 0);
    check("reset:busy", int'(busy), 0);
    check("reset:done", int'(done), 0);
    rst = 1'b0;

    watch(50);
    busy_cnt = 0;
    foreach (bh[i]) busy_cnt += bh[i];
    check("idle:strobes", sk.size(), 0);
    check("idle:dones", dk.size(), 0);
    check("idle:busy", busy_cnt, 0);
    check("idle:level", int'(level_out), 0);

    ramp("up16", 100, 16, 4, 1'b0);
    ramp("down40", 0, 40, 1, 1'b0);
    ramp("up255", 1000, 255, 1, 1'b1);
    ramp("clamp_top", 1023, 255, 1, 1'b0);
    ramp("step0", 0, 0, 3, 1'b1);

    // Retarget downward while ramping up, right after the 48 strobe.
    drive(0, 1'b0, 16, 4, 1'b1);
    drive(100, 1'b1, 0, 0, 1'b0);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (level_write && level_out == WIDTH'(48)) found = 1;
    end
    check("retarget:reach48", found, 1);
    drive(10, 1'b1, 0, 0, 1'b0);
    build(48, 10, 16);
    watch(16);
    verify("retarget", 10, 4, 3);
    cur = 10;

    build(cur, cur, 16);
    drive(cur, 1'b1, 0, 0, 1'b0);
    watch(4);
    verify("equal", cur, 4, 5);

    for (int it = 0; it < 20; it++) begin
      tgt = int'($urandom_range(0, 1023));
      stp = int'($urandom_range(0, 255));
      if (stp != 0 && stp < 8) stp = 8;
      if (it % 7 == 3) stp = 0;
      if (it % 9 == 5) tgt = cur;
      per = int'($urandom_range(0, 5));
      ramp($sformatf("rand%0d", it), tgt, stp, per, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a slow ramp.
    drive(0, 1'b0, 1, 2, 1'b1);
    drive((cur < 512) ? 1023 : 0, 1'b1, 0, 0, 1'b0);
    watch(20);
    check("midrst:ramping", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst:level", int'(level_out), 0);
    check("midrst:busy", int'(busy), 0);
    check("midrst:write", int'(level_write), 0);
    check("midrst:done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    watch(10);
    check("midrst:strobes", sk.size(), 0);
    check("midrst:final", int'(level_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
